// File: rtl/data_sram_responder_if.sv
// CPU data SRAM-like port: one request per cycle, read data returned one cycle later.
interface data_sram_responder_if;
  logic        sram_en;
  logic [3:0]  sram_wen;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;

  modport master (
    output sram_en,
    output sram_wen,
    output sram_addr,
    output sram_wdata,
    input  sram_rdata
  );

  modport slave (
    input  sram_en,
    input  sram_wen,
    input  sram_addr,
    input  sram_wdata,
    output sram_rdata
  );
endinterface

// File: rtl/data_sram_responder.sv
// Memory-side responder for the CPU data port: word RAM at 0x0 plus an MMIO bank
// (LED, switches, free-running timer, compare and timer interrupt).
module data_sram_responder #(
  parameter int          RAM_AW    = 12,
  parameter logic [31:0] CONF_BASE = 32'h1faf_0000
) (
  input  logic                        clk,
  input  logic                        resetn,
  data_sram_responder_if.slave        bus,
  input  logic [7:0]                  switch_i,
  output logic [15:0]                 led_o,
  output logic                        irq_o
);

  localparam int RAM_WORDS = 1 << RAM_AW;

  logic [31:0]       mem [RAM_WORDS];
  logic [31:0]       ram_q;

  logic [31:0]       wmask;
  logic              wr;
  logic              ram_hit;
  logic              mmio_hit;
  logic [13:0]       reg_sel;
  logic [RAM_AW-1:0] ram_idx;
  logic              unused_addr_bits;

  logic              wr_led;
  logic              wr_timer;
  logic              wr_compare;
  logic              wr_irq;

  logic [15:0]       led_reg;
  logic [15:0]       led_next;
  logic [31:0]       timer_reg;
  logic [31:0]       timer_next;
  logic [31:0]       compare_reg;
  logic [31:0]       compare_next;
  logic              pending_reg;
  logic              irq_set;
  logic              irq_clr;

  logic [31:0]       mmio_rd;
  logic [31:0]       mmio_q_reg;
  logic              src_ram_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_mask
      assign wmask[8*gi +: 8] = {8{bus.sram_wen[gi]}};
    end
  endgenerate

  assign wr               = bus.sram_en && (bus.sram_wen != 4'b0000);
  assign ram_hit          = (bus.sram_addr[31:RAM_AW+2] == '0);
  assign mmio_hit         = (bus.sram_addr[31:16] == CONF_BASE[31:16]);
  assign reg_sel          = bus.sram_addr[15:2];
  assign ram_idx          = bus.sram_addr[RAM_AW+1:2];
  assign unused_addr_bits = ^bus.sram_addr[1:0];

  assign wr_led     = wr && mmio_hit && (reg_sel == 14'd0);
  assign wr_timer   = wr && mmio_hit && (reg_sel == 14'd2);
  assign wr_compare = wr && mmio_hit && (reg_sel == 14'd3);
  assign wr_irq     = wr && mmio_hit && (reg_sel == 14'd4);

  // A software write replaces only its enabled byte lanes; other lanes keep the current value.
  always_comb begin
    led_next     = led_reg;
    timer_next   = timer_reg + 32'd1;
    compare_next = compare_reg;
    if (wr_led)
      led_next = (led_reg & ~wmask[15:0]) | (bus.sram_wdata[15:0] & wmask[15:0]);
    if (wr_timer)
      timer_next = (timer_reg & ~wmask) | (bus.sram_wdata & wmask);
    if (wr_compare)
      compare_next = (compare_reg & ~wmask) | (bus.sram_wdata & wmask);
  end

  assign irq_set = (timer_reg == compare_reg) && (compare_reg != 32'd0);
  assign irq_clr = wr_irq && bus.sram_wen[0] && bus.sram_wdata[0];

  always_comb begin
    mmio_rd = 32'd0;
    case (reg_sel)
      14'd0:   mmio_rd = {16'd0, led_reg};
      14'd1:   mmio_rd = {24'd0, switch_i};
      14'd2:   mmio_rd = timer_reg;
      14'd3:   mmio_rd = compare_reg;
      14'd4:   mmio_rd = {31'd0, pending_reg};
      default: mmio_rd = 32'd0;
    endcase
  end

  // Read-first word RAM; held off while reset is asserted so an aborted write never lands.
  always_ff @(posedge clk) begin
    if (resetn && bus.sram_en && ram_hit) begin
      ram_q <= mem[ram_idx];
      for (int i = 0; i < 4; i++) begin
        if (bus.sram_wen[i])
          mem[ram_idx][8*i +: 8] <= bus.sram_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      led_reg     <= 16'd0;
      timer_reg   <= 32'd0;
      compare_reg <= 32'd0;
      pending_reg <= 1'b0;
      mmio_q_reg  <= 32'd0;
      src_ram_reg <= 1'b0;
    end else begin
      led_reg     <= led_next;
      timer_reg   <= timer_next;
      compare_reg <= compare_next;
      pending_reg <= irq_set || (pending_reg && !irq_clr);
      if (bus.sram_en) begin
        src_ram_reg <= ram_hit;
        mmio_q_reg  <= (!ram_hit && mmio_hit) ? mmio_rd : 32'd0;
      end
    end
  end

  assign bus.sram_rdata = src_ram_reg ? ram_q : mmio_q_reg;
  assign led_o          = led_reg;
  assign irq_o          = pending_reg;

endmodule
